regs: RTL and testbench

- Architectural integer register file for the RV32I core: 32 x 32-bit registers, x0 hardwired to zero.
- Sits directly downstream of the execute stage, which drives its write port (rd address, data, write enable).
- Also serves the decode stage through two combinational read ports (rs1, rs2).
- Provides a third read-only debug port so benches can check architectural state without hierarchical references.

---
 rtl/regs_pkg.sv | 15 +
 rtl/regs.sv | 59 +++++
 tb/tb_regs.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/regs_pkg.sv
// Shared defines for the RV32I core: bus widths, register-file size and
// the common zero/enable constants used by the execute and decode stages.
package regs_pkg;

  localparam int RegNum = 32;

  typedef logic [4:0]  RegAddrBus;
  typedef logic [31:0] RegBus;

  localparam RegBus     ZeroWord     = 32'h0000_0000;
  localparam RegAddrBus ZeroReg      = 5'd0;
  localparam logic      WriteEnable  = 1'b1;
  localparam logic      WriteDisable = 1'b0;

endpackage

// File: rtl/regs.sv
// Architectural integer register file: 32 x 32-bit, x0 hardwired to zero,
// one write port from execute, two bypassed read ports for decode, one raw debug port.
module regs
  import regs_pkg::*;
#(
  parameter int REG_NUM = RegNum,
  parameter int DATA_W  = $bits(RegBus),
  localparam int AW     = $clog2(REG_NUM)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [AW-1:0]     reg_addr_i,
  input  logic [DATA_W-1:0] reg_data_i,
  input  logic              reg_wen_i,
  input  logic [AW-1:0]     rs1_addr_i,
  output logic [DATA_W-1:0] rs1_data_o,
  input  logic [AW-1:0]     rs2_addr_i,
  output logic [DATA_W-1:0] rs2_data_o,
  input  logic [AW-1:0]     dbg_addr_i,
  output logic [DATA_W-1:0] dbg_data_o
);

  logic [DATA_W-1:0] mem_q [REG_NUM];
  logic              wr_hit;

  assign wr_hit = (reg_wen_i == WriteEnable) && (reg_addr_i != '0);

  // NOTE: the array is reset asynchronously because reset must clear
  // architectural state at once; entry 0 keeps its reset value forever.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_NUM; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_hit) begin
      mem_q[reg_addr_i] <= reg_data_i;
    end
  end

  // Read side: zero during reset or for x0, then same-cycle write bypass,
  // then stored value. Debug port skips the bypass to show committed state.
  always_comb begin
    rs1_data_o = '0;
    rs2_data_o = '0;
    dbg_data_o = '0;
    if (rst_n) begin
      if (rs1_addr_i != '0) begin
        rs1_data_o = (wr_hit && reg_addr_i == rs1_addr_i) ? reg_data_i : mem_q[rs1_addr_i];
      end
      if (rs2_addr_i != '0) begin
        rs2_data_o = (wr_hit && reg_addr_i == rs2_addr_i) ? reg_data_i : mem_q[rs2_addr_i];
      end
      if (dbg_addr_i != '0) begin
        dbg_data_o = mem_q[dbg_addr_i];
      end
    end
  end

endmodule

// File: tb/tb_regs.sv
// Self-checking bench for regs: directed vector table, hand-written reset
// sequences and randomized traffic against an array-based reference model.
module tb_regs;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  reg_addr_i;
  logic [31:0] reg_data_i;
  logic        reg_wen_i;
  logic [4:0]  rs1_addr_i, rs2_addr_i, dbg_addr_i;
  logic [31:0] rs1_data_o, rs2_data_o, dbg_data_o;

  int n_total = 0;
  int n_pass  = 0;

  logic [31:0] model [32];

  regs dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .reg_addr_i (reg_addr_i),
    .reg_data_i (reg_data_i),
    .reg_wen_i  (reg_wen_i),
    .rs1_addr_i (rs1_addr_i),
    .rs1_data_o (rs1_data_o),
    .rs2_addr_i (rs2_addr_i),
    .rs2_data_o (rs2_data_o),
    .dbg_addr_i (dbg_addr_i),
    .dbg_data_o (dbg_data_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  rs1, rs2, dbg;
    logic [31:0] exp_rs1, exp_rs2, exp_dbg;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
  endtask

  task automatic drive(input logic wen, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] ad);
    reg_wen_i  = wen;
    reg_addr_i = wa;
    reg_data_i = wd;
    rs1_addr_i = a1;
    rs2_addr_i = a2;
    dbg_addr_i = ad;
  endtask

  // Reference model: architectural state is a plain array; a read sees the
  // in-flight write when enabled, nonzero and matching.
  function automatic logic [31:0] ref_read(input logic [4:0] a, input logic bypass);
    if (a == 5'd0) return 32'h0;
    if (bypass && reg_wen_i && reg_addr_i != 5'd0 && reg_addr_i == a) return reg_data_i;
    return model[a];
  endfunction

  // Advance one clock edge (inputs held), commit the pending write into the model.
  task automatic step();
    logic        w;
    logic [4:0]  a;
    logic [31:0] d;
    w = reg_wen_i; a = reg_addr_i; d = reg_data_i;
    @(posedge clk);
    #1;
    if (rst_n && w && a != 5'd0) model[a] = d;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model[i] = 32'h0;

    vecs[0]  = '{1'b1, 5'd3,  32'h1234_5678, 5'd3,  5'd0,  5'd3,  32'h1234_5678, 32'h0,         32'h0};
    vecs[1]  = '{1'b0, 5'd3,  32'h0,         5'd3,  5'd3,  5'd3,  32'h1234_5678, 32'h1234_5678, 32'h1234_5678};
    vecs[2]  = '{1'b1, 5'd7,  32'hA5A5_A5A5, 5'd7,  5'd7,  5'd7,  32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'h0};
    vecs[3]  = '{1'b1, 5'd0,  32'hFFFF_FFFF, 5'd0,  5'd7,  5'd0,  32'h0,         32'hA5A5_A5A5, 32'h0};
    vecs[4]  = '{1'b0, 5'd0,  32'h0,         5'd0,  5'd0,  5'd0,  32'h0,         32'h0,         32'h0};
    vecs[5]  = '{1'b1, 5'd10, 32'h1,         5'd10, 5'd3,  5'd10, 32'h1,         32'h1234_5678, 32'h0};
    vecs[6]  = '{1'b0, 5'd10, 32'h2,         5'd10, 5'd10, 5'd10, 32'h1,         32'h1,         32'h1};
    vecs[7]  = '{1'b0, 5'd10, 32'h2,         5'd10, 5'd10, 5'd10, 32'h1,         32'h1,         32'h1};
    vecs[8]  = '{1'b0, 5'd10, 32'h2,         5'd10, 5'd10, 5'd10, 32'h1,         32'h1,         32'h1};
    vecs[9]  = '{1'b0, 5'd10, 32'h2,         5'd10, 5'd10, 5'd10, 32'h1,         32'h1,         32'h1};
    vecs[10] = '{1'b1, 5'd7,  32'h0BAD_F00D, 5'd7,  5'd10, 5'd7,  32'h0BAD_F00D, 32'h1,         32'hA5A5_A5A5};
    vecs[11] = '{1'b0, 5'd7,  32'h0,         5'd7,  5'd7,  5'd7,  32'h0BAD_F00D, 32'h0BAD_F00D, 32'h0BAD_F00D};

    // Reset with a write pending: everything reads 0, write is lost.
    rst_n = 1'b0;
    drive(1'b1, 5'd5, 32'hDEAD_BEEF, 5'd0, 5'd0, 5'd0);
    for (int i = 0; i < 32; i++) begin
      rs1_addr_i = 5'(i); rs2_addr_i = 5'(31 - i); dbg_addr_i = 5'(i);
      #1;
      check($sformatf("rst_rs1[%0d]", i), rs1_data_o, 32'h0);
      check($sformatf("rst_rs2[%0d]", 31 - i), rs2_data_o, 32'h0);
      check($sformatf("rst_dbg[%0d]", i), dbg_data_o, 32'h0);
    end
    @(negedge clk);
    reg_wen_i = 1'b0;
    rst_n = 1'b1;
    dbg_addr_i = 5'd5;
    step();
    check("post_rst_dbg5", dbg_data_o, 32'h0);

    // Directed vector table: combinational outputs checked before each edge.
    for (int v = 0; v < 12; v++) begin
      drive(vecs[v].wen, vecs[v].waddr, vecs[v].wdata, vecs[v].rs1, vecs[v].rs2, vecs[v].dbg);
      #2;
      check($sformatf("vec%0d_rs1", v), rs1_data_o, vecs[v].exp_rs1);
      check($sformatf("vec%0d_rs2", v), rs2_data_o, vecs[v].exp_rs2);
      check($sformatf("vec%0d_dbg", v), dbg_data_o, vecs[v].exp_dbg);
      step();
    end
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
    #1;
    check("x0_after_edge", rs1_data_o, 32'h0);

    // Fill x1..x31 with their index, then async reset between edges.
    for (int i = 1; i < 32; i++) begin
      drive(1'b1, 5'(i), 32'(i), 5'd0, 5'd0, 5'd0);
      step();
    end
    drive(1'b1, 5'd9, 32'hCAFE_F00D, 5'd31, 5'd17, 5'd31);
    #1;
    check("fill_dbg31", dbg_data_o, 32'd31);
    check("fill_rs2_17", rs2_data_o, 32'd17);
    rst_n = 1'b0;
    #1;
    check("async_rst_dbg31", dbg_data_o, 32'h0);
    check("async_rst_rs1_31", rs1_data_o, 32'h0);
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    for (int i = 1; i < 32; i++) begin
      dbg_addr_i = 5'(i);
      #0.25;
      check($sformatf("async_rst_dbg[%0d]", i), dbg_data_o, 32'h0);
    end
    step();
    step();
    @(negedge clk);
    reg_wen_i = 1'b0;
    rst_n = 1'b1;
    dbg_addr_i = 5'd9;
    step();
    check("post_rst2_dbg9", dbg_data_o, 32'h0);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 3) != 0),
            5'($urandom_range(0, 7) == 0 ? 0 : $urandom_range(0, 7)),
            $urandom(),
            5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)));
      if (n % 50 == 0) reg_addr_i = rs1_addr_i;
      #2;
      check("rnd_rs1", rs1_data_o, ref_read(rs1_addr_i, 1'b1));
      check("rnd_rs2", rs2_data_o, ref_read(rs2_addr_i, 1'b1));
      check("rnd_dbg", dbg_data_o, ref_read(dbg_addr_i, 1'b0));
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
